// File: rtl/hazard_fwd_if.sv
// hazard_fwd_if
//   Bundle between the ID-stage decode logic and the hazard/forwarding unit.
//   master : the decode/datapath side. It drives the ID-stage instruction
//            description, ext_hold and cnt_clr, and it receives the pipeline
//            controls, the forward selects and the event counters.
//   slave  : the hazard_fwd_unit side (the mirror image of master).
//   Signals:
//     ext_hold, cnt_clr                   pipeline freeze / counter clear
//     id_valid, id_rs, id_rt,
//     id_use_rs, id_use_rt, id_dest,
//     id_wreg, id_load, id_branch,
//     id_jump, id_taken                   ID-stage instruction description
//     pc_we, ifid_we, ifid_flush,
//     idex_bubble                         pipeline register controls
//     fwda, fwdb                          EX operand selects (2 bits each)
//     id_fwda, id_fwdb                    branch-compare operand selects
//     stall_cnt, flush_cnt                saturating event counters
interface hazard_fwd_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
);
    logic             ext_hold;
    logic             cnt_clr;
    logic             id_valid;
    logic [RA_W-1:0]  id_rs;
    logic [RA_W-1:0]  id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [RA_W-1:0]  id_dest;
    logic             id_wreg;
    logic             id_load;
    logic             id_branch;
    logic             id_jump;
    logic             id_taken;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic [1:0]       fwda;
    logic [1:0]       fwdb;
    logic             id_fwda;
    logic             id_fwdb;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ext_hold, cnt_clr, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_dest, id_wreg, id_load, id_branch, id_jump, id_taken,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, fwda, fwdb,
               id_fwda, id_fwdb, stall_cnt, flush_cnt
    );

    modport slave (
        input  ext_hold, cnt_clr, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_dest, id_wreg, id_load, id_branch, id_jump, id_taken,
        output pc_we, ifid_we, ifid_flush, idex_bubble, fwda, fwdb,
               id_fwda, id_fwdb, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//   Hazard detection and operand-forwarding controller for a 5-stage
//   IF/ID/EX/MEM/WB pipeline. A small scoreboard records the destination of
//   the instructions in EX and MEM. From it and the ID-stage instruction this
//   unit derives the EX operand forward selects, the ID branch-compare
//   forwards, and the stall / bubble / flush controls. It also keeps
//   saturating counters of stall cycles and redirect flushes.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    hazard_fwd_if.slave (ID inputs in, pipeline controls out)
//   Parameters:
//     RA_W   register address width; register 0 is hard-wired zero
//     FWD_EN 1 = full forwarding, 0 = interlock only
//     CNT_W  width of the event counters
module hazard_fwd_unit #(
    parameter int RA_W   = 5,
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    hazard_fwd_if.slave bus
);

    // Scoreboard. The register file is write-first, so an instruction in WB
    // can never cause a hazard or a forward. Only EX and MEM are tracked.
    logic             ex_vld_q,   ex_vld_d;
    logic [RA_W-1:0]  ex_dest_q,  ex_dest_d;
    logic             ex_wreg_q,  ex_wreg_d;
    logic             ex_load_q,  ex_load_d;
    logic             mem_vld_q,  mem_vld_d;
    logic [RA_W-1:0]  mem_dest_q, mem_dest_d;
    logic             mem_wreg_q, mem_wreg_d;
    logic             mem_load_q, mem_load_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [1:0] src_stall;
    logic [3:0] fwd_sel;
    logic [1:0] br_fwd;
    logic       stall;
    logic       redirect;

    // Source slot 0 is rs and source slot 1 is rt. Each slot is resolved on
    // its own. The EX producer is younger than the MEM producer, so an EX
    // match takes precedence.
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        logic [RA_W-1:0] src;
        logic            used;
        logic            ex_hit;
        logic            mem_hit;

        assign src     = (gi == 0) ? bus.id_rs : bus.id_rt;
        assign used    = bus.id_valid & ((gi == 0) ? bus.id_use_rs : bus.id_use_rt);
        assign ex_hit  = used & ex_vld_q & ex_wreg_q
                       & (ex_dest_q == src) & (src != '0);
        assign mem_hit = used & mem_vld_q & mem_wreg_q
                       & (mem_dest_q == src) & (src != '0);

        // A branch compares in ID, so it needs its operands one stage earlier
        // than an ALU op. Any EX producer stalls it. A MEM-stage load also
        // stalls it, because the load data is not ready until WB.
        assign src_stall[gi] = FWD_EN
            ? ((ex_hit & ex_load_q) | (bus.id_branch & (ex_hit | (mem_hit & mem_load_q))))
            : (ex_hit | mem_hit);

        assign fwd_sel[2*gi +: 2] = !FWD_EN ? 2'b00
                                  : ex_hit  ? (ex_load_q  ? 2'b00 : 2'b01)
                                  : mem_hit ? (mem_load_q ? 2'b11 : 2'b10)
                                  : 2'b00;

        assign br_fwd[gi] = FWD_EN & bus.id_branch & ~ex_hit & mem_hit & ~mem_load_q;
    end

    assign stall    = |src_stall;
    assign redirect = bus.id_valid & (bus.id_jump | (bus.id_branch & bus.id_taken))
                    & ~stall & ~bus.ext_hold;

    // Pipeline controls. Reset has priority, then hold, then stall. A stall
    // masks a redirect in the same cycle. The branch is evaluated again once
    // its operands are available.
    always_comb begin
        bus.pc_we       = 1'b1;
        bus.ifid_we     = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_bubble = 1'b0;
        bus.fwda        = fwd_sel[1:0];
        bus.fwdb        = fwd_sel[3:2];
        bus.id_fwda     = br_fwd[0];
        bus.id_fwdb     = br_fwd[1];
        if (!rst_n) begin
            bus.pc_we       = 1'b0;
            bus.ifid_we     = 1'b0;
            bus.idex_bubble = 1'b1;
            bus.fwda        = 2'b00;
            bus.fwdb        = 2'b00;
            bus.id_fwda     = 1'b0;
            bus.id_fwdb     = 1'b0;
        end else if (bus.ext_hold) begin
            bus.pc_we   = 1'b0;
            bus.ifid_we = 1'b0;
        end else if (stall) begin
            bus.pc_we       = 1'b0;
            bus.ifid_we     = 1'b0;
            bus.idex_bubble = 1'b1;
        end else begin
            bus.ifid_flush = redirect;
        end
    end

    // Scoreboard advance. A stalled ID instruction enters EX as a bubble.
    always_comb begin
        ex_vld_d   = ex_vld_q;
        ex_dest_d  = ex_dest_q;
        ex_wreg_d  = ex_wreg_q;
        ex_load_d  = ex_load_q;
        mem_vld_d  = mem_vld_q;
        mem_dest_d = mem_dest_q;
        mem_wreg_d = mem_wreg_q;
        mem_load_d = mem_load_q;
        if (!bus.ext_hold) begin
            mem_vld_d  = ex_vld_q;
            mem_dest_d = ex_dest_q;
            mem_wreg_d = ex_wreg_q;
            mem_load_d = ex_load_q;
            ex_vld_d   = bus.id_valid & ~stall;
            ex_dest_d  = bus.id_dest;
            ex_wreg_d  = bus.id_wreg;
            ex_load_d  = bus.id_load;
        end
    end

    // Event counters. They saturate at all-ones, and a clear overrides any
    // increment in the same cycle.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!bus.ext_hold && stall && !(&stall_cnt_q))
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (redirect && !(&flush_cnt_q))
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_vld_q    <= 1'b0;
            ex_dest_q   <= '0;
            ex_wreg_q   <= 1'b0;
            ex_load_q   <= 1'b0;
            mem_vld_q   <= 1'b0;
            mem_dest_q  <= '0;
            mem_wreg_q  <= 1'b0;
            mem_load_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_vld_q    <= ex_vld_d;
            ex_dest_q   <= ex_dest_d;
            ex_wreg_q   <= ex_wreg_d;
            ex_load_q   <= ex_load_d;
            mem_vld_q   <= mem_vld_d;
            mem_dest_q  <= mem_dest_d;
            mem_wreg_q  <= mem_wreg_d;
            mem_load_q  <= mem_load_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus, driven into all three instances
    logic       ext_hold = 0, cnt_clr = 0, id_valid = 0;
    logic [4:0] id_rs = 0, id_rt = 0, id_dest = 0;
    logic       id_use_rs = 0, id_use_rt = 0, id_wreg = 0, id_load = 0;
    logic       id_branch = 0, id_jump = 0, id_taken = 0;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_fwd_if #(.RA_W(5), .CNT_W(16)) bus_a ();
    hazard_fwd_if #(.RA_W(5), .CNT_W(16)) bus_n ();
    hazard_fwd_if #(.RA_W(5), .CNT_W(2))  bus_s ();

    assign {bus_a.ext_hold, bus_a.cnt_clr, bus_a.id_valid, bus_a.id_rs, bus_a.id_rt, bus_a.id_use_rs, bus_a.id_use_rt,
            bus_a.id_dest, bus_a.id_wreg, bus_a.id_load, bus_a.id_branch, bus_a.id_jump, bus_a.id_taken}
         = {ext_hold, cnt_clr, id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_wreg, id_load, id_branch, id_jump, id_taken};
    assign {bus_n.ext_hold, bus_n.cnt_clr, bus_n.id_valid, bus_n.id_rs, bus_n.id_rt, bus_n.id_use_rs, bus_n.id_use_rt,
            bus_n.id_dest, bus_n.id_wreg, bus_n.id_load, bus_n.id_branch, bus_n.id_jump, bus_n.id_taken}
         = {ext_hold, cnt_clr, id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_wreg, id_load, id_branch, id_jump, id_taken};
    assign {bus_s.ext_hold, bus_s.cnt_clr, bus_s.id_valid, bus_s.id_rs, bus_s.id_rt, bus_s.id_use_rs, bus_s.id_use_rt,
            bus_s.id_dest, bus_s.id_wreg, bus_s.id_load, bus_s.id_branch, bus_s.id_jump, bus_s.id_taken}
         = {ext_hold, cnt_clr, id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_wreg, id_load, id_branch, id_jump, id_taken};

    hazard_fwd_unit #(.RA_W(5), .FWD_EN(1'b1), .CNT_W(16)) u_fwd   (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    hazard_fwd_unit #(.RA_W(5), .FWD_EN(1'b0), .CNT_W(16)) u_nofwd (.clk(clk), .rst_n(rst_n), .bus(bus_n));
    hazard_fwd_unit #(.RA_W(5), .FWD_EN(1'b1), .CNT_W(2))  u_small (.clk(clk), .rst_n(rst_n), .bus(bus_s));

    // Control bits packed as {pc_we, ifid_we, ifid_flush, idex_bubble}
    logic [3:0] ctl_a, ctl_n;
    assign ctl_a = {bus_a.pc_we, bus_a.ifid_we, bus_a.ifid_flush, bus_a.idex_bubble};
    assign ctl_n = {bus_n.pc_we, bus_n.ifid_we, bus_n.ifid_flush, bus_n.idex_bubble};

    task automatic tick();
        $display("cyc t=%0t v=%0b rs=%0d rt=%0d dst=%0d ld=%0b br=%0b hold=%0b ctl=%b fwda=%b fwdb=%b idf=%b%b sc=%0d fc=%0d",
                 $time, id_valid, id_rs, id_rt, id_dest, id_load, id_branch, ext_hold, ctl_a,
                 bus_a.fwda, bus_a.fwdb, bus_a.id_fwda, bus_a.id_fwdb, bus_a.stall_cnt, bus_a.flush_cnt);
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic [4:0] dst, input logic wr, input logic ld,
                          input logic br, input logic jp, input logic tk);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_dest = dst; id_wreg = wr; id_load = ld; id_branch = br; id_jump = jp; id_taken = tk;
    endtask

    task automatic op_alu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
        set_id(1, s, t, 1, 1, d, 1, 0, 0, 0, 0);
    endtask
    task automatic op_lw(input logic [4:0] d, input logic [4:0] b);
        set_id(1, b, 0, 1, 0, d, 1, 1, 0, 0, 0);
    endtask
    task automatic op_beq(input logic [4:0] s, input logic [4:0] t, input logic tk);
        set_id(1, s, t, 1, 1, 0, 0, 0, 1, 0, tk);
    endtask
    task automatic op_jump();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask
    task automatic op_nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Drain the pipelines and zero every counter
    task automatic idle();
        op_nop();
        cnt_clr = 1;
        repeat (3) tick();
        cnt_clr = 0;
    endtask

    task automatic test_reset();
        op_alu(6, 5, 1);
        #2;
        n_cmp++; if (ctl_a !== 4'b0001) begin n_bad++; $display("FAIL reset_ctl got=%b want=0001", ctl_a); end
        n_cmp++; if ({bus_a.fwda, bus_a.fwdb} !== 4'b0000) begin n_bad++; $display("FAIL reset_fwd got=%b want=0000", {bus_a.fwda, bus_a.fwdb}); end
        n_cmp++; if (bus_a.stall_cnt !== 16'd0 || bus_a.flush_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", bus_a.stall_cnt, bus_a.flush_cnt); end
        @(negedge clk);
        rst_n = 1;
        #1;
        n_cmp++; if (ctl_a !== 4'b1100) begin n_bad++; $display("FAIL reset_release_ctl got=%b want=1100", ctl_a); end
        tick();
    endtask

    task automatic test_alu_fwd();
        idle();
        op_alu(3, 1, 2); #1;
        n_cmp++; if (ctl_a !== 4'b1100) begin n_bad++; $display("FAIL alu_first_ctl got=%b want=1100", ctl_a); end
        tick();
        op_alu(4, 3, 3); #1;
        n_cmp++; if ({bus_a.fwda, bus_a.fwdb} !== 4'b0101) begin n_bad++; $display("FAIL alu_ex_fwd got=%b want=0101", {bus_a.fwda, bus_a.fwdb}); end
        n_cmp++; if (ctl_a !== 4'b1100) begin n_bad++; $display("FAIL alu_ex_nostall got=%b want=1100", ctl_a); end
        tick();
        idle();
        op_alu(3, 1, 2); tick();
        op_alu(9, 1, 2); tick();
        op_alu(10, 3, 9); #1;
        n_cmp++; if ({bus_a.fwda, bus_a.fwdb} !== 4'b1001) begin n_bad++; $display("FAIL alu_mem_ex_fwd got=%b want=1001", {bus_a.fwda, bus_a.fwdb}); end
        tick();
        op_alu(11, 3, 9); #1;
        n_cmp++; if ({bus_a.fwda, bus_a.fwdb} !== 4'b0010) begin n_bad++; $display("FAIL alu_wb_nofwd got=%b want=0010", {bus_a.fwda, bus_a.fwdb}); end
        tick();
    endtask

    task automatic test_load_use();
        idle();
        op_lw(5, 1); tick();
        op_alu(6, 5, 1); #1;
        n_cmp++; if (ctl_a !== 4'b0001) begin n_bad++; $display("FAIL lu_stall_ctl got=%b want=0001", ctl_a); end
        tick();
        n_cmp++; if (ctl_a !== 4'b1100) begin n_bad++; $display("FAIL lu_resume_ctl got=%b want=1100", ctl_a); end
        n_cmp++; if ({bus_a.fwda, bus_a.fwdb} !== 4'b1100) begin n_bad++; $display("FAIL lu_fwd got=%b want=1100", {bus_a.fwda, bus_a.fwdb}); end
        n_cmp++; if (bus_a.stall_cnt !== 16'd1) begin n_bad++; $display("FAIL lu_stall_cnt got=%0d want=1", bus_a.stall_cnt); end
        tick();
    endtask

    task automatic test_branch();
        idle();
        op_lw(2, 1); tick();
        op_beq(2, 0, 1); #1;
        n_cmp++; if (ctl_a !== 4'b0001) begin n_bad++; $display("FAIL br_lw_stall1 got=%b want=0001", ctl_a); end
        tick();
        n_cmp++; if (ctl_a !== 4'b0001) begin n_bad++; $display("FAIL br_lw_stall2 got=%b want=0001", ctl_a); end
        tick();
        n_cmp++; if (ctl_a !== 4'b1110 || bus_a.id_fwda !== 1'b0) begin n_bad++; $display("FAIL br_lw_flush got=%b/%b want=1110/0", ctl_a, bus_a.id_fwda); end
        tick();
        op_nop(); #1;
        n_cmp++; if (bus_a.stall_cnt !== 16'd2 || bus_a.flush_cnt !== 16'd1) begin n_bad++; $display("FAIL br_lw_cnt got=%0d/%0d want=2/1", bus_a.stall_cnt, bus_a.flush_cnt); end
        idle();
        op_alu(2, 1, 1); tick();
        op_beq(2, 0, 0); #1;
        n_cmp++; if (ctl_a !== 4'b0001) begin n_bad++; $display("FAIL br_alu_stall got=%b want=0001", ctl_a); end
        tick();
        n_cmp++; if ({ctl_a, bus_a.id_fwda, bus_a.id_fwdb} !== 6'b110010) begin n_bad++; $display("FAIL br_alu_idfwd got=%b want=110010", {ctl_a, bus_a.id_fwda, bus_a.id_fwdb}); end
        tick();
        op_jump(); #1;
        n_cmp++; if (ctl_a !== 4'b1110) begin n_bad++; $display("FAIL jump_flush got=%b want=1110", ctl_a); end
        tick();
        op_nop(); #1;
        n_cmp++; if (bus_a.stall_cnt !== 16'd1 || bus_a.flush_cnt !== 16'd1) begin n_bad++; $display("FAIL br_alu_cnt got=%0d/%0d want=1/1", bus_a.stall_cnt, bus_a.flush_cnt); end
    endtask

    task automatic test_no_fwd();
        idle();
        op_alu(7, 1, 2); #1;
        n_cmp++; if (ctl_n !== 4'b1100) begin n_bad++; $display("FAIL nf_first_ctl got=%b want=1100", ctl_n); end
        tick();
        op_alu(8, 7, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (ctl_n !== 4'b0001 || bus_n.fwda !== 2'b00) begin n_bad++; $display("FAIL nf_stall%0d got=%b/%b want=0001/00", i, ctl_n, bus_n.fwda); end
            tick();
        end
        n_cmp++; if (ctl_n !== 4'b1100 || bus_n.fwda !== 2'b00) begin n_bad++; $display("FAIL nf_resume got=%b/%b want=1100/00", ctl_n, bus_n.fwda); end
        n_cmp++; if (bus_n.stall_cnt !== 16'd2) begin n_bad++; $display("FAIL nf_stall_cnt got=%0d want=2", bus_n.stall_cnt); end
        tick();
    endtask

    task automatic test_hold();
        idle();
        op_lw(5, 1); tick();
        op_alu(6, 5, 1);
        ext_hold = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (ctl_a !== 4'b0000 || bus_a.stall_cnt !== 16'd0) begin n_bad++; $display("FAIL hold%0d got=%b/%0d want=0000/0", i, ctl_a, bus_a.stall_cnt); end
            tick();
        end
        ext_hold = 0; #1;
        n_cmp++; if (ctl_a !== 4'b0001) begin n_bad++; $display("FAIL hold_release_stall got=%b want=0001", ctl_a); end
        tick();
        n_cmp++; if (ctl_a !== 4'b1100 || bus_a.fwda !== 2'b11 || bus_a.stall_cnt !== 16'd1) begin
            n_bad++; $display("FAIL hold_resolve got=%b/%b/%0d want=1100/11/1", ctl_a, bus_a.fwda, bus_a.stall_cnt); end
        tick();
    endtask

    task automatic test_zero_reg();
        idle();
        op_alu(0, 1, 2); tick();
        op_alu(4, 0, 0); #1;
        n_cmp++; if ({ctl_a, bus_a.fwda, bus_a.fwdb} !== 8'b11000000) begin n_bad++; $display("FAIL zero_alu got=%b want=11000000", {ctl_a, bus_a.fwda, bus_a.fwdb}); end
        tick();
        op_lw(0, 1); tick();
        op_alu(4, 0, 0); #1;
        n_cmp++; if ({ctl_a, bus_a.fwda, bus_a.fwdb} !== 8'b11000000) begin n_bad++; $display("FAIL zero_lw got=%b want=11000000", {ctl_a, bus_a.fwda, bus_a.fwdb}); end
        tick();
    endtask

    task automatic test_saturate();
        idle();
        for (int i = 0; i < 5; i++) begin
            op_lw(5, 1); tick();
            op_alu(6, 5, 1); tick(); tick();
            if (i == 1) begin
                n_cmp++; if (bus_s.stall_cnt !== 2'd2) begin n_bad++; $display("FAIL sat_mid got=%0d want=2", bus_s.stall_cnt); end
            end
        end
        n_cmp++; if (bus_s.stall_cnt !== 2'd3) begin n_bad++; $display("FAIL sat_hold got=%0d want=3", bus_s.stall_cnt); end
        op_lw(5, 1); tick();
        op_alu(6, 5, 1);
        cnt_clr = 1; tick();
        cnt_clr = 0; #1;
        n_cmp++; if (bus_s.stall_cnt !== 2'd0) begin n_bad++; $display("FAIL sat_clr_priority got=%0d want=0", bus_s.stall_cnt); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        idle();
        op_lw(2, 1); tick();
        op_beq(2, 0, 1); tick();
        n_cmp++; if (ctl_a !== 4'b0001 || bus_a.stall_cnt !== 16'd1) begin n_bad++; $display("FAIL rms_pre got=%b/%0d want=0001/1", ctl_a, bus_a.stall_cnt); end
        rst_n = 0; #1;
        n_cmp++; if (ctl_a !== 4'b0001 || bus_a.stall_cnt !== 16'd0) begin n_bad++; $display("FAIL rms_in_reset got=%b/%0d want=0001/0", ctl_a, bus_a.stall_cnt); end
        @(negedge clk);
        rst_n = 1; #1;
        n_cmp++; if (ctl_a !== 4'b1110) begin n_bad++; $display("FAIL rms_release got=%b want=1110", ctl_a); end
        tick();
        n_cmp++; if (bus_a.stall_cnt !== 16'd0 || bus_a.flush_cnt !== 16'd1) begin n_bad++; $display("FAIL rms_cnt got=%0d/%0d want=0/1", bus_a.stall_cnt, bus_a.flush_cnt); end
        op_nop();
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_branch();
        test_no_fwd();
        test_hold();
        test_zero_reg();
        test_saturate();
        test_reset_mid_stall();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
